prefetch_bus_unit: RTL and testbench
====================================

Name: prefetch_bus_unit

Overview:
Parametrised bus control unit for the v30mz core. It replaces the fixed prefetch loop with a configurable-depth byte prefetch queue, plus an arbitrated data-access path for the execution unit. It handles odd-address single-byte code fetch, split odd-word data accesses and branch flush. It sits between the external 16-bit bus and execution_unit.

Parameters:
QUEUE_DEPTH, 8, queue capacity in bytes; power of 2, >= 4
RESET_PS, 16'hFFFF, PS value loaded at reset
RESET_PC, 16'h0000, fetch PC loaded at reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset)
readyb  in  1  active-low bus cycle completion; data_in valid when 0
data_in  in  16  bus read data
address_out  out  20  physical bus address
bus_status  out  4  F idle, 9 code fetch, A data read, B data write
bus_byte_en  out  2  bit0 low byte lane, bit1 high byte lane
data_out  out  16  bus write data, lane-aligned
flush  in  1  discard queue, restart fetch at flush_ps:flush_pc
flush_ps  in  16  new PS
flush_pc  in  16  new fetch PC
pop  in  2  bytes consumed this cycle (0,1,2)
queue_data  out  16  [7:0] head byte, [15:8] next byte
queue_count  out  $clog2(QUEUE_DEPTH+1)  bytes held
pfp  out  16  PC of head byte
eu_req  in  1  data access request, held until eu_ready
eu_write  in  1  1 write, 0 read
eu_word  in  1  1 word, 0 byte
eu_address  in  20  physical data address
eu_data  in  16  write data (byte in [7:0])
eu_ready  out  1  one-cycle done pulse
eu_rdata  out  16  read data, valid with eu_ready

Behaviour:
- Reset (async, reset=0): queue_count=0, pfp=fetch_pc=RESET_PC, PS=RESET_PS, bus_status=F, address_out={RESET_PS,4'd0}+RESET_PC (FFFF0 default), bus_byte_en=0, data_out=0, eu_ready=0, eu_rdata=0, FSM=IDLE. Reset mid-cycle abandons the cycle.
- FSM states: IDLE, FETCH, DATA_LO, DATA_HI, TIDLE. All bus outputs registered.
- IDLE arbitration (per cycle): eu_req has priority; otherwise code fetch if space allows; otherwise stay IDLE.
- Code fetch eligibility: even fetch_pc requires free >= 2 (word, byte_en=11); odd fetch_pc requires free >= 1 (byte, byte_en=10, take data_in[15:8]). Even fetch_pc with free=1: no fetch.
- Address = {PS,4'd0} + {4'd0,fetch_pc} for fetch; eu_address for data. Low bit is not masked.
- Cycle timing: decision at edge N; address/status driven from N+1; completes at first edge where readyb=0; push visible and queue_count updated the cycle after; fetch_pc += bytes fetched (16-bit wrap); then TIDLE for one cycle (bus_status=F) before IDLE.
- Data access: even address or byte access uses one cycle (DATA_LO). Byte lane = address[0]; write data placed on that lane; read byte returned in eu_rdata[7:0], [15:8]=0. Odd word uses DATA_LO (addr, lane hi, low byte) then DATA_HI (addr+1, lane lo, high byte), with TIDLE between. eu_ready pulses the cycle after final completion.
- Queue: circular byte buffer; push 1/2 and pop 0/1/2 in the same cycle allowed; count = count + pushed - popped. pfp += pop (wrap). pop > queue_count is illegal: ignored, no state change, simulation assertion.
- queue_data bytes beyond queue_count are don't-care.
- Flush (highest priority): same-cycle pop/push ignored; queue_count=0, PS=flush_ps, fetch_pc=pfp=flush_pc next cycle. An in-flight FETCH completes on bus but its data is discarded (squash bit), then TIDLE. In-flight data cycles complete normally and are unaffected.
- Wrap: fetch_pc FFFF→0000 within the same PS; physical address wraps at 20 bits.
- eu_req deasserted before eu_ready is illegal.

Test Plan:
- Reset release, readyb=0 always, no pops → fetches at FFFF0,FFFF2,FFFF4,FFFF6 each separated by bus_status F; queue_count reaches 8, then bus idle.
- Flush to PS=1000, PC=0003 → first fetch address 10003, byte_en=10, one byte pushed; next fetch 10004 word; pfp=0003.
- Flush asserted while fetch awaits readyb (held 1 for 3 cycles) → that cycle's data not pushed; queue_count=0, next fetch at flush address.
- eu_req word write addr 00101, data ABCD, concurrent with fetch need → data first: cycle at 00101 lane hi data_out[15:8]=CD, then 00102 lane lo data_out[7:0]=AB; one eu_ready pulse.
- Queue full (8), pop=2 with simultaneous word push → queue_count stays 8; pop with pop=2 at count 1 → ignored, assertion fires.
- Byte read at 20000 returns data_in=1234 → eu_rdata=0034; at 20001 → eu_rdata=0012.

Source files
------------

// File: rtl/prefetch_bus_unit.sv
// prefetch_bus_unit: byte prefetch queue plus arbitrated data path onto the 16-bit v30mz bus.
// Data requests win arbitration; odd words split into two byte cycles; flush squashes an in-flight fetch.
module prefetch_bus_unit #(
  parameter int          QUEUE_DEPTH = 8,
  parameter logic [15:0] RESET_PS    = 16'hFFFF,
  parameter logic [15:0] RESET_PC    = 16'h0000
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 readyb,
  input  logic [15:0]                          data_in,
  output logic [19:0]                          address_out,
  output logic [3:0]                           bus_status,
  output logic [1:0]                           bus_byte_en,
  output logic [15:0]                          data_out,
  input  logic                                 flush,
  input  logic [15:0]                          flush_ps,
  input  logic [15:0]                          flush_pc,
  input  logic [1:0]                           pop,
  output logic [15:0]                          queue_data,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]     queue_count,
  output logic [15:0]                          pfp,
  input  logic                                 eu_req,
  input  logic                                 eu_write,
  input  logic                                 eu_word,
  input  logic [19:0]                          eu_address,
  input  logic [15:0]                          eu_data,
  output logic                                 eu_ready,
  output logic [15:0]                          eu_rdata
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH+1);
  localparam logic [3:0] ST_IDLE = 4'hF, ST_CODE = 4'h9, ST_RD = 4'hA, ST_WR = 4'hB;
  typedef enum logic [2:0] {IDLE, FETCH, DATA_LO, DATA_HI, TIDLE} state_t;
  state_t state_q, state_d;
  logic [15:0] ps_q, ps_d, fpc_q, fpc_d, pfp_q, pfp_d;
  logic [AW-1:0] rd_q, rd_d, rd1, wr0, wr1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic squash_q, squash_d, hi_q, hi_d, rdy_q, rdy_d;
  logic [19:0] addr_q, addr_d, fetch_addr;
  logic [3:0] st_q, st_d;
  logic [1:0] be_q, be_d, push_n, pop_n;
  logic [15:0] dout_q, dout_d, rdata_q, rdata_d;
  logic [7:0] mem_q [QUEUE_DEPTH];
  logic done, pop_ok, can_fetch, odd_word;
  assign done = ~readyb;
  assign odd_word = eu_word & eu_address[0];
  assign pop_ok = pop != 2'd3 && CW'(pop) <= cnt_q;
  assign pop_n = (flush || !pop_ok) ? 2'd0 : pop;
  assign push_n = (state_q == FETCH && done && !squash_q && !flush) ? (fpc_q[0] ? 2'd1 : 2'd2) : 2'd0;
  assign can_fetch = !flush && (fpc_q[0] ? int'(cnt_q) < QUEUE_DEPTH : int'(cnt_q) <= QUEUE_DEPTH - 2);
  assign fetch_addr = {ps_q, 4'd0} + {4'd0, fpc_q};
  assign wr0 = rd_q + AW'(cnt_q);
  assign wr1 = wr0 + AW'(1);
  assign rd1 = rd_q + AW'(1);
  assign queue_data = {mem_q[rd1], mem_q[rd_q]};
  assign queue_count = cnt_q;
  assign pfp = pfp_q;
  assign address_out = addr_q;
  assign bus_status = st_q;
  assign bus_byte_en = be_q;
  assign data_out = dout_q;
  assign eu_ready = rdy_q;
  assign eu_rdata = rdata_q;
  always_comb begin
    rd_d = flush ? rd_q : rd_q + AW'(pop_n);
    cnt_d = flush ? '0 : cnt_q + CW'(push_n) - CW'(pop_n);
    pfp_d = flush ? flush_pc : pfp_q + 16'(pop_n);
    fpc_d = flush ? flush_pc : fpc_q + 16'(push_n);
    ps_d = flush ? flush_ps : ps_q;
  end
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    st_d = st_q;
    be_d = be_q;
    dout_d = dout_q;
    rdata_d = rdata_q;
    rdy_d = 1'b0;
    hi_d = hi_q;
    squash_d = squash_q | (state_q == FETCH && flush);
    case (state_q)
      IDLE: begin
        if (eu_req) begin
          state_d = DATA_LO;
          addr_d = eu_address;
          st_d = eu_write ? ST_WR : ST_RD;
          be_d = (eu_word && !eu_address[0]) ? 2'b11 : {eu_address[0], ~eu_address[0]};
          dout_d = (eu_word && !eu_address[0]) ? eu_data :
                   eu_address[0] ? {eu_data[7:0], 8'h00} : {8'h00, eu_data[7:0]};
        end else if (can_fetch) begin
          state_d = FETCH;
          addr_d = fetch_addr;
          st_d = ST_CODE;
          be_d = fpc_q[0] ? 2'b10 : 2'b11;
          squash_d = 1'b0;
        end
      end
      FETCH, DATA_LO, DATA_HI: begin
        if (done) begin
          state_d = TIDLE;
          st_d = ST_IDLE;
          be_d = 2'b00;
          rdy_d = state_q == DATA_HI || (state_q == DATA_LO && !odd_word);
          hi_d = state_q == DATA_LO && odd_word;
          rdata_d = state_q == FETCH ? rdata_q :
                    state_q == DATA_HI ? {data_in[7:0], rdata_q[7:0]} :
                    (eu_word && !eu_address[0]) ? data_in :
                    {8'h00, eu_address[0] ? data_in[15:8] : data_in[7:0]};
        end
      end
      TIDLE: begin
        state_d = hi_q ? DATA_HI : IDLE;
        if (hi_q) begin
          addr_d = eu_address + 20'd1;
          st_d = eu_write ? ST_WR : ST_RD;
          be_d = 2'b01;
          dout_d = {8'h00, eu_data[15:8]};
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ps_q <= RESET_PS;
      fpc_q <= RESET_PC;
      pfp_q <= RESET_PC;
      rd_q <= '0;
      cnt_q <= '0;
      squash_q <= 1'b0;
      hi_q <= 1'b0;
      addr_q <= {RESET_PS, 4'd0} + {4'd0, RESET_PC};
      st_q <= ST_IDLE;
      be_q <= 2'b00;
      dout_q <= '0;
      rdata_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ps_q <= ps_d;
      fpc_q <= fpc_d;
      pfp_q <= pfp_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      squash_q <= squash_d;
      hi_q <= hi_d;
      addr_q <= addr_d;
      st_q <= st_d;
      be_q <= be_d;
      dout_q <= dout_d;
      rdata_q <= rdata_d;
      rdy_q <= rdy_d;
    end
  end
  // Tail slot is independent of same-cycle pops, so pushes never collide with the head.
  always_ff @(posedge clk) begin
    if (push_n != 2'd0) mem_q[wr0] <= data_in[fpc_q[0] ? 15 : 7 -: 8];
    if (push_n == 2'd2) mem_q[wr1] <= data_in[15:8];
  end
  always @(posedge clk)
    if (reset && !flush) assert (pop_ok) else $warning("prefetch_bus_unit: pop exceeds queue_count, ignored");
endmodule

// File: tb/tb_prefetch_bus_unit.sv
// tb_prefetch_bus_unit: transaction-level model of queue and bus cycles, compared every cycle,
// plus literal expectations for reset, fetch sequence, flush, split writes, byte reads and wrap.
module tb_prefetch_bus_unit;
  localparam int D = 8;
  localparam logic [3:0] F = 4'hF;
  logic clk = 0, reset = 0, readyb = 0, flush = 0, eu_req = 0, eu_write = 0, eu_word = 0;
  logic [15:0] data_in = 0, flush_ps = 0, flush_pc = 0, eu_data = 0;
  logic [1:0] pop = 0;
  logic [19:0] eu_address = 0;
  logic [19:0] address_out;
  logic [3:0] bus_status, queue_count;
  logic [1:0] bus_byte_en;
  logic [15:0] data_out, queue_data, pfp, eu_rdata, rd;
  logic eu_ready;
  int tests = 0, fails = 0, rdy_cnt = 0;
  always #5 clk = ~clk;
  prefetch_bus_unit #(.QUEUE_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .readyb(readyb), .data_in(data_in), .address_out(address_out),
    .bus_status(bus_status), .bus_byte_en(bus_byte_en), .data_out(data_out), .flush(flush),
    .flush_ps(flush_ps), .flush_pc(flush_pc), .pop(pop), .queue_data(queue_data),
    .queue_count(queue_count), .pfp(pfp), .eu_req(eu_req), .eu_write(eu_write), .eu_word(eu_word),
    .eu_address(eu_address), .eu_data(eu_data), .eu_ready(eu_ready), .eu_rdata(eu_rdata));
  // model: kind 0 none, 1 code fetch, 2 data first/only cycle, 3 data second cycle
  logic [7:0] q[$];
  logic [15:0] m_ps = 16'hFFFF, m_fpc = 0, m_pfp = 0, m_dout = 0, m_rdata = 0;
  logic [19:0] m_addr = 0;
  logic [3:0] m_st = F, prev_st = F;
  logic [1:0] m_be = 0;
  int m_kind = 0;
  bit m_tidle = 0, m_hi = 0, m_squash = 0, m_rdy = 0;
  typedef struct packed {logic [3:0] st; logic [1:0] be; logic [19:0] addr; logic [15:0] dout;} ent_t;
  ent_t log_q[$];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic start_data(input bit hi);
    m_kind = hi ? 3 : 2;
    m_st = eu_write ? 4'hB : 4'hA;
    m_addr = hi ? eu_address + 20'd1 : eu_address;
    m_be = hi ? 2'b01 : (eu_word && !eu_address[0]) ? 2'b11 : (eu_address[0] ? 2'b10 : 2'b01);
    m_dout = hi ? {8'h00, eu_data[15:8]} : (eu_word && !eu_address[0]) ? eu_data : {2{eu_data[7:0]}};
  endtask
  task automatic predict();
    bit done = m_kind != 0 && !readyb;
    bit fdone = m_kind == 1 && done && !m_squash;
    int n = q.size();
    m_rdy = 0;
    if (m_kind != 0) begin
      if (done) begin
        if (m_kind == 2 && eu_word && eu_address[0]) begin
          m_hi = 1;
          m_rdata[7:0] = data_in[15:8];
        end else if (m_kind == 2) begin
          m_rdy = 1;
          m_rdata = eu_word ? data_in : {8'h00, eu_address[0] ? data_in[15:8] : data_in[7:0]};
        end else if (m_kind == 3) begin
          m_hi = 0;
          m_rdy = 1;
          m_rdata[15:8] = data_in[7:0];
        end
        m_kind = 0; m_tidle = 1; m_st = F; m_be = 0;
      end
    end else if (m_tidle) begin
      m_tidle = 0;
      if (m_hi) start_data(1);
    end else if (eu_req) start_data(0);
    else if (!flush && (D - n) >= (m_fpc[0] ? 1 : 2)) begin
      m_kind = 1; m_st = 4'h9; m_squash = 0;
      m_addr = {m_ps, 4'h0} + {4'h0, m_fpc};
      m_be = m_fpc[0] ? 2'b10 : 2'b11;
    end
    if (flush) begin
      q.delete();
      m_ps = flush_ps; m_fpc = flush_pc; m_pfp = flush_pc;
      if (m_kind == 1) m_squash = 1;
    end else begin
      if (pop != 2'd3 && int'(pop) <= n) begin
        repeat (int'(pop)) void'(q.pop_front());
        m_pfp = m_pfp + 16'(pop);
      end
      if (fdone && m_fpc[0]) begin
        q.push_back(data_in[15:8]);
        m_fpc = m_fpc + 16'd1;
      end else if (fdone) begin
        q.push_back(data_in[7:0]);
        q.push_back(data_in[15:8]);
        m_fpc = m_fpc + 16'd2;
      end
    end
  endtask
  task automatic compare();
    logic [15:0] mask = {{8{m_be[1]}}, {8{m_be[0]}}};
    check("count", queue_count, q.size());
    check("pfp", pfp, m_pfp);
    if (q.size() >= 1) check("qdata_lo", queue_data[7:0], q[0]);
    if (q.size() >= 2) check("qdata_hi", queue_data[15:8], q[1]);
    check("status", bus_status, m_st);
    check("byte_en", bus_byte_en, m_be);
    if (m_st != F) check("address", address_out, m_addr);
    if (m_st == 4'hB) check("wdata", data_out & mask, m_dout & mask);
    check("eu_ready", eu_ready, m_rdy);
    if (m_rdy && !eu_write) check("eu_rdata", eu_rdata, m_rdata);
    if (bus_status != F && prev_st == F) log_q.push_back('{bus_status, bus_byte_en, address_out, data_out});
    prev_st = bus_status;
    if (eu_ready) rdy_cnt++;
  endtask
  task automatic cycle();
    predict();
    @(negedge clk);
    compare();
  endtask
  task automatic eu_op(input bit w, input bit wd, input logic [19:0] a, input logic [15:0] d, output logic [15:0] r);
    eu_req = 1; eu_write = w; eu_word = wd; eu_address = a; eu_data = d;
    for (int i = 0; i < 40 && !eu_ready; i++) cycle();
    check("eu_done", eu_ready, 1);
    r = eu_rdata;
    eu_req = 0;
    cycle();
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    check("rst_addr", address_out, 20'hFFFF0);
    check("rst_status", bus_status, F);
    check("rst_be", bus_byte_en, 0);
    check("rst_dout", data_out, 0);
    check("rst_count", queue_count, 0);
    check("rst_pfp", pfp, 0);
    check("rst_ready", eu_ready, 0);
    check("rst_rdata", eu_rdata, 0);
    reset = 1;
    data_in = 16'h2211;
    repeat (16) cycle();
    check("a_nfetch", log_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("a_addr", log_q[i].addr, 20'hFFFF0 + 20'(2 * i));
      check("a_st_be", {log_q[i].st, log_q[i].be}, {4'h9, 2'b11});
    end
    check("a_full", queue_count, 8);
    check("a_qdata", queue_data, 16'h2211);
    check("a_idle", bus_status, F);
    log_q.delete();
    pop = 2; readyb = 1; cycle();
    pop = 0; cycle(); cycle();
    flush = 1; flush_ps = 16'h1000; flush_pc = 16'h0003; cycle();
    flush = 0;
    check("b_flush_count", queue_count, 0);
    check("b_flush_pfp", pfp, 16'h0003);
    cycle();
    readyb = 0; cycle();
    check("b_squash_count", queue_count, 0);
    repeat (12) cycle();
    check("b_stale", log_q[0].addr, 20'hFFFF8);
    check("b_first", {log_q[1].st, log_q[1].be, log_q[1].addr}, {4'h9, 2'b10, 20'h10003});
    check("b_second", {log_q[2].st, log_q[2].be, log_q[2].addr}, {4'h9, 2'b11, 20'h10004});
    check("b_pfp", pfp, 16'h0003);
    log_q.delete(); rdy_cnt = 0;
    pop = 2; cycle(); pop = 0;
    eu_op(1, 1, 20'h00101, 16'hABCD, rd);
    repeat (8) cycle();
    check("c_lo", {log_q[0].st, log_q[0].be, log_q[0].addr, log_q[0].dout[15:8]}, {4'hB, 2'b10, 20'h00101, 8'hCD});
    check("c_hi", {log_q[1].st, log_q[1].be, log_q[1].addr, log_q[1].dout[7:0]}, {4'hB, 2'b01, 20'h00102, 8'hAB});
    check("c_fetch_after", {log_q[2].st, log_q[2].addr}, {4'h9, 20'h1000A});
    check("c_one_ready", rdy_cnt, 1);
    data_in = 16'h1234;
    eu_op(0, 0, 20'h20000, 16'h0000, rd);
    check("d_rd_even", rd, 16'h0034);
    eu_op(0, 0, 20'h20001, 16'h0000, rd);
    check("d_rd_odd", rd, 16'h0012);
    data_in = 16'h2211;
    flush = 1; flush_ps = 16'h1000; flush_pc = 16'h0003; cycle();
    flush = 0;
    for (int i = 0; i < 20 && queue_count != 1; i++) cycle();
    readyb = 1;
    check("e_one", queue_count, 1);
    pop = 2; cycle(); pop = 0;
    check("e_pop_ignored", queue_count, 1);
    check("e_pfp_kept", pfp, 16'h0003);
    check("e_head", queue_data[7:0], 8'h22);
    flush = 1; flush_ps = 16'hFFFF; flush_pc = 16'hFFFD; readyb = 0; cycle();
    flush = 0; log_q.delete();
    repeat (15) cycle();
    check("w_byte", {log_q[0].be, log_q[0].addr}, {2'b10, 20'h0FFED});
    check("w_word", {log_q[1].be, log_q[1].addr}, {2'b11, 20'h0FFEE});
    check("w_pcwrap", {log_q[2].be, log_q[2].addr}, {2'b11, 20'hFFFF0});
    for (int i = 0; i < 3000; i++) begin
      if (m_rdy) eu_req = 0;
      else if (!eu_req && $urandom_range(0, 7) == 0) begin
        eu_req = 1; eu_write = 1'($urandom); eu_word = 1'($urandom);
        eu_address = 20'($urandom); eu_data = 16'($urandom);
      end
      readyb = $urandom_range(0, 2) == 0;
      data_in = 16'($urandom);
      flush = $urandom_range(0, 24) == 0;
      flush_ps = 16'($urandom); flush_pc = 16'($urandom);
      pop = flush ? 2'd0 : 2'($urandom_range(0, q.size() < 2 ? q.size() : 2));
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
